fc_neuron_mac: RTL and testbench



---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_neuron_mac_lane_mac_tree.sv | 33 +++
 rtl/fc_neuron_mac.sv | 151 +++++++++++++++
 tb/tb_fc_neuron_mac.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and width helpers for the sequential fully-connected neuron
// datapath and for other layers that reuse its lane tree.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FLUSH,
    OUT
  } fc_state_e;

  // Accumulator must hold IN full-scale products plus a bias of the same range.
  function automatic int acc_width(input int width, input int in_n);
    return 2 * width + $clog2(in_n) + 1;
  endfunction

  function automatic int psum_width(input int width, input int lanes);
    return 2 * width + $clog2(lanes);
  endfunction

  function automatic int beat_count(input int in_n, input int lanes);
    return in_n / lanes;
  endfunction

endpackage

// File: rtl/fc_neuron_mac_lane_mac_tree.sv
// LANES-way signed multiply followed by a balanced pairwise adder tree.
// Purely combinational; each tree level grows the operand width by one bit.
module lane_mac_tree #(
  parameter int WIDTH = 8,
  parameter int LANES = 8
) (
  input  logic [LANES*WIDTH-1:0]              x,
  input  logic [LANES*WIDTH-1:0]              w,
  output logic [2*WIDTH+$clog2(LANES)-1:0]    psum
);

  localparam int LEVELS = $clog2(LANES);

  genvar l, n;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NW = 2 * WIDTH + l;
    localparam int NN = LANES >> l;
    logic signed [NW-1:0] sum [NN];

    if (l == 0) begin : g_leaf
      for (n = 0; n < NN; n++) begin : g_mul
        assign sum[n] = NW'($signed(x[n*WIDTH +: WIDTH])) * NW'($signed(w[n*WIDTH +: WIDTH]));
      end
    end else begin : g_add
      for (n = 0; n < NN; n++) begin : g_node
        assign sum[n] = NW'(g_lvl[l-1].sum[2*n]) + NW'(g_lvl[l-1].sum[2*n+1]);
      end
    end
  end

  assign psum = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/fc_neuron_mac.sv
// Streaming fully-connected neuron: LANES products per beat, accumulated over
// IN/LANES beats. Define FC_NEURON_RELU_EN to clamp negative results to zero.
module fc_neuron_mac
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int LANES = 8,
  localparam int ACC_W = acc_width(WIDTH, IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] w,
  input  logic [ACC_W-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       z
);

  localparam int BEATS  = beat_count(IN, LANES);
  localparam int PSUM_W = psum_width(WIDTH, LANES);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((IN % LANES) != 0) begin : g_bad_in
    $error("fc_neuron_mac: IN must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > IN || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("fc_neuron_mac: LANES must be a power of two in 1..IN");
  end

  fc_state_e                state_q, state_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic signed [PSUM_W-1:0] psum_q, psum_d;
  logic                     psum_vld_q, psum_vld_d;
  logic                     first_q, first_d;
  logic signed [ACC_W-1:0]  bias_q, bias_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]         z_q, z_d;
  logic                     out_valid_q, out_valid_d;

  logic [PSUM_W-1:0]        tree_sum;
  logic [ACC_W-1:0]         z_next;
  logic                     accept;
  logic                     last_beat;

  lane_mac_tree #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_tree (
    .x    (x),
    .w    (w),
    .psum (tree_sum)
  );

`ifdef FC_NEURON_RELU_EN
  assign z_next = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign z_next = acc_q;
`endif

  assign in_ready  = rst_n && (state_q == IDLE || state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    psum_d      = psum_q;
    psum_vld_d  = 1'b0;
    first_d     = first_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;

    // Stage 1: register the lane sum; the first beat of a vector also latches bias.
    if (accept) begin
      psum_d     = $signed(tree_sum);
      psum_vld_d = 1'b1;
      first_d    = (state_q == IDLE);
      if (state_q == IDLE) begin
        bias_d = $signed(bias);
      end
      if (last_beat) begin
        beat_cnt_d = '0;
        state_d    = FLUSH;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (state_q == IDLE) begin
          state_d = ACC;
        end
      end
    end

    // Stage 2: the first partial sum of a vector starts from bias, not the old total.
    if (psum_vld_q) begin
      acc_d = (first_q ? bias_q : acc_q) + ACC_W'(psum_q);
    end

    case (state_q)
      FLUSH: begin
        // Once the last partial sum has landed in acc, the total is final.
        if (!psum_vld_q) begin
          z_d         = z_next;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      bias_q      <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      psum_q      <= psum_d;
      psum_vld_q  <= psum_vld_d;
      first_q     <= first_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Self-checking bench for fc_neuron_mac: directed and randomized vectors
// compared against a plain dot-product reference model.
module tb_fc_neuron_mac;

  localparam int WIDTH = 8;
  localparam int IN_N  = 128;
  localparam int LANES = 8;
  localparam int BEATS = IN_N / LANES;
  localparam int ACC_W = 2 * WIDTH + $clog2(IN_N) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] x = '0;
  logic [LANES*WIDTH-1:0] w = '0;
  logic [ACC_W-1:0]       bias = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [ACC_W-1:0]       z;

  int n_tests = 0;
  int n_fail  = 0;
  int vx [IN_N];
  int vw [IN_N];

  fc_neuron_mac #(
    .WIDTH (WIDTH),
    .IN    (IN_N),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef FC_NEURON_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: bias plus dot product, wrapped to ACC_W bits as a signed value.
  function automatic longint ref_z(input longint b);
    longint s = b;
    longint m = longint'(1) << ACC_W;
    for (int i = 0; i < IN_N; i++) s += longint'(vx[i]) * longint'(vw[i]);
    s = s % m;
    if (s < 0) s += m;
    if (s >= m / 2) s -= m;
    return relu(s);
  endfunction

  task automatic fill(input int xv, input int wv);
    for (int i = 0; i < IN_N; i++) begin
      vx[i] = xv;
      vw[i] = wv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IN_N; i++) begin
      vx[i] = int'($urandom_range(0, 255)) - 128;
      vw[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  function automatic longint rand_bias();
    return longint'($urandom_range(0, (1 << ACC_W) - 1)) - (longint'(1) << (ACC_W - 1));
  endfunction

  // Runs at 1 time unit after a rising edge; returns there after the last accepted beat.
  task automatic send_beats(input int n_beats, input longint b, input bit gaps, output int cycles);
    int  beat;
    bit  go;
    bit  take;
    beat   = 0;
    cycles = 0;
    while (beat < n_beats && cycles < 2000) begin
      go = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid = go;
      for (int k = 0; k < LANES; k++) begin
        x[k*WIDTH +: WIDTH] = go ? WIDTH'(vx[beat*LANES+k]) : WIDTH'($urandom);
        w[k*WIDTH +: WIDTH] = go ? WIDTH'(vw[beat*LANES+k]) : WIDTH'($urandom);
      end
      bias = (go && beat == 0) ? ACC_W'(b) : ACC_W'($urandom);
      take = go && in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (take) beat++;
    end
    in_valid = 1'b0;
    x        = WIDTH'($urandom) * LANES;
    bias     = ACC_W'($urandom);
    if (beat < n_beats) check("send_timeout", beat, n_beats);
  endtask

  // Called right after the last beat: checks 2-cycle latency, result, hold and handshake.
  task automatic take_output(input string tag, input longint exp, input int hold);
    int n;
    bit ir_high;
    n       = 0;
    ir_high = 1'b0;
    while (!out_valid && n < 50) begin
      if (in_ready) ir_high = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready) ir_high = 1'b1;
    check({tag, "_latency"}, n, 2);
    check({tag, "_out_valid"}, longint'(out_valid), 1);
    check({tag, "_in_ready_low"}, longint'(ir_high), 0);
    check({tag, "_z"}, longint'($signed(z)), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, longint'(out_valid), 1);
      check({tag, "_hold_z"}, longint'($signed(z)), exp);
      check({tag, "_hold_in_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, longint'(out_valid), 0);
    check({tag, "_ready_back"}, longint'(in_ready), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int     cyc;
    longint b;
    longint e;

    // Reset state.
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_z", longint'($signed(z)), 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", longint'(in_ready), 1);

    // All ones, continuous stream.
    fill(1, 1);
    send_beats(BEATS, 0, 1'b0, cyc);
    check("ones_beat_cycles", cyc, BEATS);
    check("ones_flush_in_ready", longint'(in_ready), 0);
    take_output("ones", 128, 0);

    // Largest positive products.
    fill(-128, -128);
    send_beats(BEATS, 0, 1'b0, cyc);
    take_output("negneg", 2097152, 0);

    // Largest negative products.
    fill(-128, 127);
    send_beats(BEATS, 0, 1'b0, cyc);
    take_output("negpos", relu(-2080768), 0);

    // Bias only, then back-to-back vector with a different bias.
    fill(0, 0);
    for (int i = 0; i < IN_N; i++) vw[i] = int'($urandom_range(0, 255)) - 128;
    send_beats(BEATS, -5, 1'b0, cyc);
    take_output("bias_neg", relu(-5), 0);
    send_beats(BEATS, 7, 1'b0, cyc);
    check("b2b_beat_cycles", cyc, BEATS);
    take_output("bias_pos", 7, 0);

    // Back-pressure on the result, then immediate next vector.
    out_ready = 1'b0;
    fill_rand();
    b = rand_bias();
    e = ref_z(b);
    send_beats(BEATS, b, 1'b0, cyc);
    take_output("hold", e, 5);
    fill_rand();
    b = rand_bias();
    e = ref_z(b);
    send_beats(BEATS, b, 1'b0, cyc);
    check("after_hold_beat_cycles", cyc, BEATS);
    take_output("after_hold", e, 0);

    // Random data with random input gaps.
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      b = rand_bias();
      e = ref_z(b);
      send_beats(BEATS, b, 1'b1, cyc);
      take_output("rand_gap", e, 0);
    end

    // Reset in the middle of a vector discards the partial sum.
    fill(5, 5);
    send_beats(7, 1000, 1'b0, cyc);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_z", longint'($signed(z)), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_back", longint'(in_ready), 1);
    fill(2, 3);
    send_beats(BEATS, 1, 1'b0, cyc);
    take_output("midrst", 769, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
